// File: rtl/agc_gain_ctrl.sv
// AGC gain-decision controller: EMA-smoothed |I|+|Q| magnitude, block-wise
// compare against a programmable target band, one-step gain moves, and a
// settling hold-off after every change.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | loop disabled; EMA frozen, counters cleared
// S_ACQUIRE | counting accepted samples toward the next decision
// S_DECIDE  | one cycle: compare EMA with band, step gain
// S_HOLD    | settling after a gain change; EMA runs, samples not counted
module agc_gain_ctrl #(
   parameter int W_MAG     = 27,
   parameter int W_GAIN    = 8,
   parameter int GAIN_INIT = 128,
   parameter int EMA_SHIFT = 4,
   parameter int BLOCK_LEN = 64,
   parameter int HOLD_CYC  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Enable,
   input  logic [W_MAG-1:0]  Mag_in,
   input  logic              Mag_valid,
   input  logic [W_MAG-1:0]  Target,
   input  logic [W_MAG-1:0]  Tol,
   output logic [W_GAIN-1:0] Gain_out,
   output logic              Gain_valid,
   output logic              Locked,
   output logic [W_MAG-1:0]  Ema_out
);

   localparam int W_CNT  = $clog2(BLOCK_LEN + 1);
   localparam int W_HOLD = $clog2(HOLD_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACQUIRE,
      S_DECIDE,
      S_HOLD
   } state_t;

   state_t              r_state;
   logic [W_MAG-1:0]    r_ema;
   logic [W_CNT-1:0]    r_cnt;
   logic [W_HOLD-1:0]   r_hold;
   logic [W_GAIN-1:0]   r_gain;
   logic                r_gain_valid;
   logic                r_locked;

   logic signed [W_MAG:0] w_diff;
   logic signed [W_MAG:0] w_step;
   logic [W_MAG-1:0]      w_ema_nxt;
   logic                  w_ema_upd;
   logic [W_MAG:0]        w_hi;
   logic [W_MAG:0]        w_lo;
   logic [W_MAG:0]        w_ema_x;
   logic                  w_above;
   logic                  w_below;
   logic [W_GAIN-1:0]     w_gain_req;
   logic                  w_gain_chg;

   // EMA step: signed difference, arithmetic shift, wrap back to W_MAG bits.
   // The shifted step never overshoots Mag_in, so the truncation is exact.
   always_comb begin
      w_diff    = $signed({1'b0, Mag_in}) - $signed({1'b0, r_ema});
      w_step    = w_diff >>> EMA_SHIFT;
      w_ema_nxt = W_MAG'({1'b0, r_ema} + w_step);
      w_ema_upd = Enable && Mag_valid && (r_state != S_IDLE);
   end

   // Band compare and saturating one-step gain request.
   // hi keeps its carry bit; lo floors at zero instead of wrapping.
   always_comb begin
      w_hi       = {1'b0, Target} + {1'b0, Tol};
      w_lo       = (Target >= Tol) ? {1'b0, Target - Tol} : '0;
      w_ema_x    = {1'b0, r_ema};
      w_above    = w_ema_x > w_hi;
      w_below    = w_ema_x < w_lo;
      w_gain_req = r_gain;
      if (w_above && (r_gain != '0)) begin
         w_gain_req = r_gain - W_GAIN'(1);
      end else if (w_below && (r_gain != '1)) begin
         w_gain_req = r_gain + W_GAIN'(1);
      end
      w_gain_chg = (w_gain_req != r_gain);
   end

   // Control FSM with EMA register, block/hold timers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_ema        <= '0;
         r_cnt        <= '0;
         r_hold       <= '0;
         r_gain       <= W_GAIN'(GAIN_INIT);
         r_gain_valid <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_gain_valid <= 1'b0;
         if (w_ema_upd) begin
            r_ema <= w_ema_nxt;
         end
         if (!Enable) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hold   <= '0;
            r_locked <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_ACQUIRE;
               end
               S_ACQUIRE: begin
                  if (Mag_valid) begin
                     if (r_cnt == W_CNT'(BLOCK_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DECIDE;
                     end else begin
                        r_cnt <= r_cnt + W_CNT'(1);
                     end
                  end
               end
               S_DECIDE: begin
                  r_gain       <= w_gain_req;
                  r_gain_valid <= 1'b1;
                  r_locked     <= !w_above && !w_below;
                  if (w_gain_chg) begin
                     // down-counter: HOLD_CYC-1 .. 0 gives HOLD_CYC cycles in HOLD
                     r_hold  <= W_HOLD'(HOLD_CYC - 1);
                     r_state <= S_HOLD;
                  end else begin
                     r_state <= S_ACQUIRE;
                  end
               end
               S_HOLD: begin
                  if (r_hold == '0) begin
                     r_state <= S_ACQUIRE;
                  end else begin
                     r_hold <= r_hold - W_HOLD'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign Gain_out   = r_gain;
   assign Gain_valid = r_gain_valid;
   assign Locked     = r_locked;
   assign Ema_out    = r_ema;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Bench for agc_gain_ctrl: four instances share one stimulus stream and are
// compared every cycle against a flag-based behavioural model.
module tb_agc_gain_ctrl;

   localparam int NI = 4;
   localparam int BL = 4;
   localparam int HC = 8;
   localparam int SH_T [NI] = '{0, 4, 0, 0};
   localparam int GI_T [NI] = '{128, 128, 255, 0};
   localparam logic [26:0] MAXV = '1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en  = 1'b0;
   logic        mv  = 1'b0;
   logic [26:0] mag = '0;
   logic [26:0] tgt = '0;
   logic [26:0] tol = '0;

   logic [7:0]  g  [NI];
   logic [26:0] e  [NI];
   logic        gv [NI];
   logic        lk [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      agc_gain_ctrl #(
         .W_MAG(27), .W_GAIN(8), .GAIN_INIT(GI_T[k]), .EMA_SHIFT(SH_T[k]),
         .BLOCK_LEN(BL), .HOLD_CYC(HC)
      ) u_dut (
         .clk(clk), .rst(rst), .Enable(en), .Mag_in(mag), .Mag_valid(mv),
         .Target(tgt), .Tol(tol), .Gain_out(g[k]), .Gain_valid(gv[k]),
         .Locked(lk[k]), .Ema_out(e[k])
      );
   end

   // ---------------- behavioural reference model ----------------
   longint m_ema  [NI];
   int     m_gain [NI];
   bit     m_lk   [NI];
   bit     m_gv   [NI];
   bit     m_on   [NI];
   bit     m_dec  [NI];
   int     m_blk  [NI];
   int     m_hold [NI];

   function automatic longint ema_next(longint cur, longint x, int s);
      longint d, p, q;
      d = x - cur;
      p = longint'(1) << s;
      if (d >= 0) q = d / p;
      else        q = -((-d + p - 1) / p);
      return cur + q;
   endfunction

   task automatic model_clear(int i);
      m_ema[i] = 0; m_gain[i] = GI_T[i]; m_lk[i] = 0; m_gv[i] = 0;
      m_on[i] = 0; m_dec[i] = 0; m_blk[i] = 0; m_hold[i] = 0;
   endtask

   task automatic model_clock(int i);
      longint ema0, hi, lo;
      int want, ng;
      ema0 = m_ema[i];
      m_gv[i] = 0;
      if (!en) begin
         m_on[i] = 0; m_blk[i] = 0; m_hold[i] = 0; m_dec[i] = 0; m_lk[i] = 0;
         return;
      end
      if (!m_on[i]) begin
         m_on[i] = 1;
         return;
      end
      if (m_dec[i]) begin
         hi = longint'(tgt) + longint'(tol);
         lo = longint'(tgt) - longint'(tol);
         if (lo < 0) lo = 0;
         want = (ema0 > hi) ? -1 : (ema0 < lo) ? 1 : 0;
         ng = m_gain[i] + want;
         if (ng < 0)   ng = 0;
         if (ng > 255) ng = 255;
         m_hold[i] = (ng != m_gain[i]) ? HC : 0;
         m_gain[i] = ng;
         m_gv[i]   = 1;
         m_lk[i]   = (want == 0);
         m_dec[i]  = 0;
      end else if (m_hold[i] > 0) begin
         m_hold[i]--;
      end else if (mv) begin
         m_blk[i]++;
         if (m_blk[i] == BL) begin
            m_blk[i] = 0;
            m_dec[i] = 1;
         end
      end
      if (mv) m_ema[i] = ema_next(ema0, longint'(mag), SH_T[i]);
   endtask

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < NI; i++) begin
         if (rst) model_clear(i);
         else     model_clock(i);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      rst = 1'b1; en = 1'b0; mv = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      en = 1'b0; mv = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (g[i] !== 8'(GI_T[i]) || e[i] !== 27'd0 || lk[i] !== 1'b0 || gv[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut%0d: got gain=%0d ema=%0d lock=%0b gv=%0b, want gain=%0d ema=0 lock=0 gv=0",
                     i, g[i], e[i], lk[i], gv[i], GI_T[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_step_down();
      int p1 = -1, p2 = -1;
      do_reset();
      tgt = 1000; tol = 50; mag = 2000; mv = 1'b1; en = 1'b1;
      for (int c = 0; c < 100 && p2 < 0; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
               n_fail++;
               $display("FAIL lockstep step_down dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                        i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
            end
         end
         if (gv[0]) begin
            n_tests++;
            if (p1 < 0) begin
               p1 = c;
               if (g[0] !== 8'd127 || lk[0] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL step_down first: got gain=%0d lock=%0b, want 127/0", g[0], lk[0]);
               end
            end else begin
               p2 = c;
               if (g[0] !== 8'd126 || lk[0] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL step_down second: got gain=%0d lock=%0b, want 126/0", g[0], lk[0]);
               end
            end
         end
      end
      n_tests++;
      if (p1 != 5) begin
         n_fail++;
         $display("FAIL step_down latency: got %0d, want 5", p1);
      end
      n_tests++;
      if (p2 < 0 || p2 - p1 != HC + 5) begin
         n_fail++;
         $display("FAIL step_down period: got %0d, want %0d", p2 - p1, HC + 5);
      end
   endtask

   task automatic test_in_band();
      int p1 = -1, p2 = -1;
      do_reset();
      tgt = 1000; tol = 50; mag = 1040; mv = 1'b1; en = 1'b1;
      for (int c = 0; c < 100 && p2 < 0; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
               n_fail++;
               $display("FAIL lockstep in_band dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                        i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
            end
         end
         if (gv[0]) begin
            if (p1 < 0) p1 = c;
            else        p2 = c;
            n_tests++;
            if (g[0] !== 8'd128 || lk[0] !== 1'b1) begin
               n_fail++;
               $display("FAIL in_band decision: got gain=%0d lock=%0b, want 128/1", g[0], lk[0]);
            end
         end
      end
      n_tests++;
      if (p1 != 5 || p2 - p1 != 5) begin
         n_fail++;
         $display("FAIL in_band timing: got first=%0d gap=%0d, want 5/5", p1, p2 - p1);
      end
   endtask

   task automatic test_saturation();
      for (int ph = 0; ph < 2; ph++) begin
         int d = 2 + ph;
         int p1 = -1, p2 = -1;
         logic [7:0] want_g = (ph == 0) ? 8'd255 : 8'd0;
         do_reset();
         tgt = 1000; tol = 0; mag = (ph == 0) ? 27'd10 : 27'd5000; mv = 1'b1; en = 1'b1;
         for (int c = 0; c < 100 && p2 < 0; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
               n_tests++;
               if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
                  n_fail++;
                  $display("FAIL lockstep saturation dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                           i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
               end
            end
            if (gv[d]) begin
               if (p1 < 0) p1 = c;
               else        p2 = c;
               n_tests++;
               if (g[d] !== want_g || lk[d] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL saturation dut%0d: got gain=%0d lock=%0b, want %0d/0", d, g[d], lk[d], want_g);
               end
            end
         end
         n_tests++;
         if (p1 != 5 || p2 - p1 != 5) begin
            n_fail++;
            $display("FAIL saturation dut%0d timing: got first=%0d gap=%0d, want 5/5 (no hold)", d, p1, p2 - p1);
         end
      end
   endtask

   typedef struct {
      logic [26:0] t;
      logic [26:0] w;
      logic [26:0] m;
      logic [7:0]  eg;
      logic        el;
   } band_row_t;

   task automatic test_band_edges();
      band_row_t rows [7];
      rows[0] = '{t: 27'd1000, w: 27'd2000, m: 27'd0,    eg: 8'd128, el: 1'b1};
      rows[1] = '{t: MAXV,     w: 27'd10,   m: MAXV,     eg: 8'd128, el: 1'b1};
      rows[2] = '{t: 27'd1000, w: 27'd50,   m: 27'd1050, eg: 8'd128, el: 1'b1};
      rows[3] = '{t: 27'd1000, w: 27'd50,   m: 27'd1051, eg: 8'd127, el: 1'b0};
      rows[4] = '{t: 27'd1000, w: 27'd50,   m: 27'd950,  eg: 8'd128, el: 1'b1};
      rows[5] = '{t: 27'd1000, w: 27'd50,   m: 27'd949,  eg: 8'd129, el: 1'b0};
      rows[6] = '{t: 27'd0,    w: 27'd0,    m: 27'd0,    eg: 8'd128, el: 1'b1};
      foreach (rows[r]) begin
         bit seen = 0;
         do_reset();
         tgt = rows[r].t; tol = rows[r].w; mag = rows[r].m; mv = 1'b1; en = 1'b1;
         for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
               n_tests++;
               if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
                  n_fail++;
                  $display("FAIL lockstep band row%0d dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                           r, i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
               end
            end
            if (gv[0]) begin
               seen = 1;
               n_tests++;
               if (g[0] !== rows[r].eg || lk[0] !== rows[r].el) begin
                  n_fail++;
                  $display("FAIL band row%0d: got gain=%0d lock=%0b, want %0d/%0b", r, g[0], lk[0], rows[r].eg, rows[r].el);
               end
            end
         end
         n_tests++;
         if (!seen) begin
            n_fail++;
            $display("FAIL band row%0d: no decision pulse within 20 cycles", r);
         end
      end
   endtask

   task automatic test_ema_shift4();
      int exp_e [3] = '{100, 193, 280};
      int p = -1;
      do_reset();
      tgt = 1000; tol = 50; mag = 1600; mv = 1'b0; en = 1'b1;
      @(negedge clk);
      mv = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_tests++;
         if (e[1] !== 27'(exp_e[k])) begin
            n_fail++;
            $display("FAIL ema_shift4 sample%0d: got ema=%0d, want %0d", k + 1, e[1], exp_e[k]);
         end
      end
      @(negedge clk);
      en = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
               n_fail++;
               $display("FAIL lockstep abort dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                        i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
            end
         end
         n_tests++;
         if (gv[0] !== 1'b0 || g[0] !== 8'd128 || gv[1] !== 1'b0 || e[1] !== 27'd362) begin
            n_fail++;
            $display("FAIL abort decide: got gv0=%0b gain0=%0d gv1=%0b ema1=%0d, want 0/128/0/362", gv[0], g[0], gv[1], e[1]);
         end
      end
      en = 1'b1;
      for (int c = 0; c < 20 && p < 0; c++) begin
         @(negedge clk);
         if (gv[0]) p = c;
      end
      n_tests++;
      if (p != 5 || g[0] !== 8'd127) begin
         n_fail++;
         $display("FAIL re-enable block: got pulse at %0d gain=%0d, want 5/127", p, g[0]);
      end
   endtask

   task automatic test_reset_async();
      int p = -1;
      do_reset();
      tgt = 1000; tol = 50; mag = 2000; mv = 1'b1; en = 1'b1;
      repeat (16) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         n_tests++;
         if (g[i] !== 8'(GI_T[i]) || e[i] !== 27'd0 || lk[i] !== 1'b0 || gv[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL async reset dut%0d: got gain=%0d ema=%0d lock=%0b gv=%0b, want %0d/0/0/0",
                     i, g[i], e[i], lk[i], gv[i], GI_T[i]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20 && p < 0; c++) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
               n_fail++;
               $display("FAIL lockstep post-reset dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                        i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
            end
         end
         if (gv[0]) p = c;
      end
      n_tests++;
      if (p != 5 || g[0] !== 8'd127) begin
         n_fail++;
         $display("FAIL post-reset block: got pulse at %0d gain=%0d, want 5/127", p, g[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      tgt = 1000; tol = 50;
      for (int c = 0; c < 4000; c++) begin
         int m;
         if ($urandom_range(0, 99) == 0) begin
            tgt = 27'($urandom_range(0, 4000));
            tol = 27'($urandom_range(0, 300));
         end
         if ($urandom_range(0, 49) == 0) begin
            mag = ($urandom_range(0, 1) == 0) ? MAXV : 27'd0;
         end else begin
            m = int'(tgt) + int'($urandom_range(0, 1200)) - 600;
            if (m < 0) m = 0;
            mag = 27'(m);
         end
         en = ($urandom_range(0, 99) >= 3);
         mv = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            n_tests++;
            if (g[i] !== 8'(m_gain[i]) || e[i] !== 27'(m_ema[i]) || lk[i] !== m_lk[i] || gv[i] !== m_gv[i]) begin
               n_fail++;
               $display("FAIL lockstep random dut%0d t=%0t: got g=%0d e=%0d lk=%0b gv=%0b want g=%0d e=%0d lk=%0b gv=%0b",
                        i, $time, g[i], e[i], lk[i], gv[i], m_gain[i], m_ema[i], m_lk[i], m_gv[i]);
            end
         end
      end
   endtask

   initial begin
      #1 rst = 1'b1;
      test_reset();
      test_step_down();
      test_in_band();
      test_saturation();
      test_band_edges();
      test_ema_shift4();
      test_reset_async();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
